// File: rtl/bus_rr_arbiter_if.sv
// +--------------------------------------------------------------------------+
// | bus_rr_arbiter_if : request/lock/grant bundle between masters and arbiter |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

interface bus_rr_arbiter_if #(
  parameter int NUM_M = 4,
  parameter int ID_W  = 2
);
  logic [NUM_M-1:0] req;
  logic [NUM_M-1:0] lock;
  logic [NUM_M-1:0] grant;
  logic [ID_W-1:0]  grant_id;
  logic             busy;
  logic             preempt;

  modport master (
    output req,
    output lock,
    input  grant,
    input  grant_id,
    input  busy,
    input  preempt
  );

  modport slave (
    input  req,
    input  lock,
    output grant,
    output grant_id,
    output busy,
    output preempt
  );
endinterface

`default_nettype wire

// File: rtl/bus_rr_arbiter.sv
// +--------------------------------------------------------------------------+
// | bus_rr_arbiter : round-robin bus arbiter, registered one-hot grant,       |
// | dead cycle between tenures, hold-time preemption unless owner locks.      |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module bus_rr_arbiter #(
  parameter int NUM_M    = 4,
  parameter int ID_W     = 2,
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  bus_rr_arbiter_if.slave  bus
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam logic [HOLD_W-1:0] c_hold_sat   = HOLD_W'(MAX_HOLD - 1);
  localparam logic [ID_W-1:0]   c_last_reset = ID_W'(NUM_M - 1);

  state_t            state_q, state_d;
  logic [NUM_M-1:0]  grant_q, grant_d;
  logic [ID_W-1:0]   grant_id_q, grant_id_d;
  logic              busy_q, busy_d;
  logic              preempt_q, preempt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [ID_W-1:0]   last_owner_q, last_owner_d;

  logic              w_pick_found;
  logic [ID_W-1:0]   w_pick_id;
  logic              w_owner_req;
  logic              w_owner_lock;
  logic              w_others_req;
  logic              w_hold_sat;

  // Search starts one past the previous owner, so it lands last in line.
  always_comb begin : rr_search
    int idx;
    idx          = 0;
    w_pick_found = 1'b0;
    w_pick_id    = '0;
    for (int k = 1; k <= NUM_M; k++) begin
      idx = (int'(last_owner_q) + k) % NUM_M;
      if (!w_pick_found && bus.req[idx]) begin
        w_pick_found = 1'b1;
        w_pick_id    = ID_W'(idx);
      end
    end
  end

  assign w_owner_req  = bus.req[grant_id_q];
  assign w_owner_lock = bus.lock[grant_id_q];
  assign w_others_req = |(bus.req & ~grant_q);
  assign w_hold_sat   = (hold_cnt_q == c_hold_sat);

  always_comb begin : fsm_next
    state_d      = state_q;
    grant_d      = grant_q;
    grant_id_d   = grant_id_q;
    busy_d       = busy_q;
    preempt_d    = 1'b0;
    hold_cnt_d   = hold_cnt_q;
    last_owner_d = last_owner_q;

    case (state_q)
      ST_IDLE: begin
        if (w_pick_found) begin
          state_d      = ST_GRANT;
          grant_d      = NUM_M'(1) << w_pick_id;
          grant_id_d   = w_pick_id;
          busy_d       = 1'b1;
          last_owner_d = w_pick_id;
          hold_cnt_d   = '0;
        end
      end
      ST_GRANT: begin
        // Voluntary release wins over preemption when both apply.
        if (!w_owner_req) begin
          state_d    = ST_IDLE;
          grant_d    = '0;
          grant_id_d = '0;
          busy_d     = 1'b0;
          hold_cnt_d = '0;
        end else if (w_hold_sat && !w_owner_lock && w_others_req) begin
          state_d    = ST_IDLE;
          grant_d    = '0;
          grant_id_d = '0;
          busy_d     = 1'b0;
          hold_cnt_d = '0;
          preempt_d  = 1'b1;
        end else if (!w_hold_sat) begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      default: begin
        state_d    = ST_IDLE;
        grant_d    = '0;
        grant_id_d = '0;
        busy_d     = 1'b0;
        hold_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin : fsm_regs
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      grant_id_q   <= '0;
      busy_q       <= 1'b0;
      preempt_q    <= 1'b0;
      hold_cnt_q   <= '0;
      last_owner_q <= c_last_reset;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      grant_id_q   <= grant_id_d;
      busy_q       <= busy_d;
      preempt_q    <= preempt_d;
      hold_cnt_q   <= hold_cnt_d;
      last_owner_q <= last_owner_d;
    end
  end

  assign bus.grant    = grant_q;
  assign bus.grant_id = grant_id_q;
  assign bus.busy     = busy_q;
  assign bus.preempt  = preempt_q;

endmodule

`default_nettype wire
